// File: rtl/apb_master_ctrl.sv
// APB requester: accepts one command at a time on a valid/ready interface,
// runs the APB SETUP/ACCESS sequence, waits on PREADY (optionally bounded by
// a timeout) and returns a single-cycle response with read data and status.
module apb_master_ctrl #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              PCLK,
    input  logic              PRESET,
    // command side
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    // response side
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              rsp_timeout,
    // APB bus
    output logic              PSEL,
    output logic              PENABLE,
    output logic [ADDR_W-1:0] PADDR,
    output logic              PWRITE,
    output logic [DATA_W-1:0] PWDATA,
    input  logic [DATA_W-1:0] PRDATA,
    input  logic              PREADY,
    input  logic              PSLVERR
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } state_t;

    // A TIMEOUT of 0 disables the abort; the counter still needs one bit.
    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    // The abort fires on the wait edge that would bring the count to TIMEOUT.
    localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t              state_q,       state_d;
    logic [ADDR_W-1:0]   paddr_q,       paddr_d;
    logic                pwrite_q,      pwrite_d;
    logic [DATA_W-1:0]   pwdata_q,      pwdata_d;
    logic [CNT_W-1:0]    wait_cnt_q,    wait_cnt_d;
    logic                rsp_valid_q,   rsp_valid_d;
    logic [DATA_W-1:0]   rsp_rdata_q,   rsp_rdata_d;
    logic                rsp_err_q,     rsp_err_d;
    logic                rsp_timeout_q, rsp_timeout_d;

    // Next-state and response computation for the SETUP/ACCESS sequencer.
    always_comb begin
        state_d       = state_q;
        paddr_d       = paddr_q;
        pwrite_d      = pwrite_q;
        pwdata_d      = pwdata_q;
        wait_cnt_d    = wait_cnt_q;
        rsp_valid_d   = 1'b0;
        rsp_rdata_d   = '0;
        rsp_err_d     = 1'b0;
        rsp_timeout_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    paddr_d  = cmd_addr;
                    pwrite_d = cmd_write;
                    // Reads never expose stale or caller-supplied write data.
                    pwdata_d = cmd_write ? cmd_wdata : '0;
                    state_d  = ST_SETUP;
                end else begin
                    state_d  = ST_IDLE;
                end
            end
            ST_SETUP: begin
                wait_cnt_d = '0;
                state_d    = ST_ACCESS;
            end
            ST_ACCESS: begin
                if (PREADY) begin
                    // PSLVERR only matters on the completing edge.
                    state_d     = ST_IDLE;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = pwrite_q ? '0 : PRDATA;
                    rsp_err_d   = PSLVERR;
                end else if ((TIMEOUT > 0) && (wait_cnt_q == CNT_LAST)) begin
                    state_d       = ST_IDLE;
                    rsp_valid_d   = 1'b1;
                    rsp_err_d     = 1'b1;
                    rsp_timeout_d = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, bus-phase and response registers with synchronous reset.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_q       <= ST_IDLE;
            paddr_q       <= '0;
            pwrite_q      <= 1'b0;
            pwdata_q      <= '0;
            wait_cnt_q    <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_err_q     <= 1'b0;
            rsp_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            paddr_q       <= paddr_d;
            pwrite_q      <= pwrite_d;
            pwdata_q      <= pwdata_d;
            wait_cnt_q    <= wait_cnt_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_err_q     <= rsp_err_d;
            rsp_timeout_q <= rsp_timeout_d;
        end
    end

    // Bus controls decode straight from the state register (no input paths).
    assign cmd_ready   = (state_q == ST_IDLE);
    assign PSEL        = (state_q == ST_SETUP) || (state_q == ST_ACCESS);
    assign PENABLE     = (state_q == ST_ACCESS);
    assign PADDR       = paddr_q;
    assign PWRITE      = pwrite_q;
    assign PWDATA      = pwdata_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign rsp_err     = rsp_err_q;
    assign rsp_timeout = rsp_timeout_q;

endmodule

// File: tb/tb_apb_master_ctrl.sv
// Self-checking bench for apb_master_ctrl: scripted APB completer, response
// scoreboard with expected completion cycle, and bus-phase checks.
module tb_apb_master_ctrl;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 4;

    logic          PCLK = 1'b0;
    logic          PRESET = 1'b1;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic          cmd_write = 1'b0;
    logic [AW-1:0] cmd_addr = '0;
    logic [DW-1:0] cmd_wdata = '0;
    logic          rsp_valid;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_err;
    logic          rsp_timeout;
    logic          PSEL;
    logic          PENABLE;
    logic [AW-1:0] PADDR;
    logic          PWRITE;
    logic [DW-1:0] PWDATA;
    logic [DW-1:0] PRDATA = '0;
    logic          PREADY = 1'b0;
    logic          PSLVERR = 1'b0;

    apb_master_ctrl #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .PCLK(PCLK), .PRESET(PRESET),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .rsp_timeout(rsp_timeout),
        .PSEL(PSEL), .PENABLE(PENABLE), .PADDR(PADDR), .PWRITE(PWRITE),
        .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
    );

    always #5 PCLK = ~PCLK;

    typedef struct {
        logic          wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] rdata;
        int            waits;
        logic          slverr;
    } txn_t;

    typedef struct {
        int            edge_n;
        logic [DW-1:0] rdata;
        logic          err;
        logic          to;
    } exp_t;

    txn_t slq[$];
    exp_t expq[$];
    int   n_tests = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   last_acc = 0;
    int   acc_cnt = 0;
    bit   mon_en = 1'b0;

    // Count rising edges so responses can be checked against their due cycle.
    always @(posedge PCLK) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    // Response scoreboard and handshake sanity, sampled mid-cycle.
    always @(negedge PCLK) begin
        exp_t e;
        if (mon_en) begin
            check_eq("ready_vs_psel", 64'(cmd_ready), 64'(!PSEL));
            if (PENABLE) check_eq("enable_needs_sel", 64'(PSEL), 64'd1);
            if (rsp_valid) begin
                if (expq.size() == 0) begin
                    check_eq("rsp_unexpected", 64'd1, 64'd0);
                end else begin
                    e = expq.pop_front();
                    check_eq("rsp_cycle", 64'(cyc), 64'(e.edge_n));
                    check_eq("rsp_rdata", 64'(rsp_rdata), 64'(e.rdata));
                    check_eq("rsp_err", 64'(rsp_err), 64'(e.err));
                    check_eq("rsp_timeout", 64'(rsp_timeout), 64'(e.to));
                end
            end else begin
                check_eq("rsp_idle_zero", 64'({rsp_rdata, rsp_err, rsp_timeout}), 64'd0);
            end
        end
    end

    // Scripted completer: holds PREADY low for 'waits' ACCESS cycles, with
    // PSLVERR high and junk PRDATA while waiting, then completes.
    always @(negedge PCLK) begin
        txn_t t;
        if (PSEL && PENABLE && slq.size() > 0) begin
            t = slq[0];
            acc_cnt++;
            check_eq("access_paddr", 64'(PADDR), 64'(t.addr));
            check_eq("access_pwrite", 64'(PWRITE), 64'(t.wr));
            check_eq("access_pwdata", 64'(PWDATA), t.wr ? 64'(t.wdata) : 64'd0);
            if (acc_cnt - 1 == t.waits) begin
                PREADY  = 1'b1;
                PRDATA  = t.rdata;
                PSLVERR = t.slverr;
            end else begin
                PREADY  = 1'b0;
                PRDATA  = 32'hBAD0_BAD0;
                PSLVERR = 1'b1;
            end
        end else begin
            if (PSEL && slq.size() > 0) begin
                t = slq[0];
                check_eq("setup_paddr", 64'(PADDR), 64'(t.addr));
                check_eq("setup_penable", 64'(PENABLE), 64'd0);
            end
            if (acc_cnt > 0 && !PENABLE) begin
                void'(slq.pop_front());
                acc_cnt = 0;
            end
            PREADY  = 1'b0;
            PRDATA  = '0;
            PSLVERR = 1'b0;
        end
    end

    // Present one command (called at a falling edge) and schedule its response.
    task automatic send(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                        input logic [DW-1:0] rdata, input int waits, input logic slverr);
        txn_t t;
        exp_t e;
        bit   to;
        int   guard = 0;
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = addr;
        cmd_wdata = wdata;
        while (!cmd_ready && guard < 50) begin
            @(negedge PCLK);
            guard++;
        end
        if (!cmd_ready) begin
            check_eq("accept_timeout", 64'd0, 64'd1);
            cmd_valid = 1'b0;
            return;
        end
        t.wr = wr; t.addr = addr; t.wdata = wdata; t.rdata = rdata;
        t.waits = waits; t.slverr = slverr;
        slq.push_back(t);
        to       = (waits >= TO);
        e.edge_n = cyc + 1 + 2 + (to ? TO - 1 : waits);
        e.rdata  = (to || wr) ? '0 : rdata;
        e.err    = to || slverr;
        e.to     = to;
        expq.push_back(e);
        last_acc = cyc + 1;
        @(posedge PCLK);
        @(negedge PCLK);
        cmd_valid = 1'b0;
    endtask

    task automatic drain();
        int guard = 0;
        while (expq.size() != 0 && guard < 100) begin
            @(negedge PCLK);
            guard++;
        end
        if (expq.size() != 0) begin
            check_eq("drain_timeout", 64'(expq.size()), 64'd0);
            expq.delete();
        end
        @(negedge PCLK);
    endtask

    initial begin
        int a1;
        PRESET = 1'b1;
        repeat (2) @(negedge PCLK);
        check_eq("reset_cmd_ready", 64'(cmd_ready), 64'd1);
        check_eq("reset_bus", 64'({PSEL, PENABLE, PWRITE}), 64'd0);
        check_eq("reset_paddr", 64'(PADDR), 64'd0);
        check_eq("reset_pwdata", 64'(PWDATA), 64'd0);
        check_eq("reset_rsp", 64'({rsp_valid, rsp_rdata, rsp_err, rsp_timeout}), 64'd0);
        PRESET = 1'b0;
        mon_en = 1'b1;
        @(negedge PCLK);

        // zero-wait write, waited read, slave error, timeouts
        send(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 32'h5555_AAAA, 0, 1'b0);
        drain();
        send(1'b0, 32'h0000_0020, 32'hFFFF_FFFF, 32'h1234_5678, 3, 1'b0);
        drain();
        send(1'b0, 32'h0000_0030, 32'h0, 32'hA5A5_0001, 0, 1'b1);
        drain();
        send(1'b0, 32'h0000_0040, 32'h0, 32'h7777_7777, 10, 1'b0);
        drain();
        send(1'b1, 32'h0000_0044, 32'h0BAD_F00D, 32'h0, 6, 1'b0);
        drain();
        send(1'b1, 32'h0000_0048, 32'h1111_2222, 32'h0, 1, 1'b1);
        drain();

        // back-to-back zero-wait transfers
        send(1'b1, 32'h0000_0100, 32'hCAFE_0001, 32'h0, 0, 1'b0);
        a1 = last_acc;
        send(1'b0, 32'h0000_0104, 32'h0, 32'hCAFE_F00D, 0, 1'b0);
        check_eq("b2b_spacing", 64'(last_acc - a1), 64'd3);
        drain();
        check_eq("idle_paddr_hold", 64'(PADDR), 64'h104);
        check_eq("idle_pwrite_hold", 64'(PWRITE), 64'd0);

        // reset in the middle of ACCESS
        send(1'b0, 32'h0000_0050, 32'h0, 32'h0000_0011, 2, 1'b0);
        @(negedge PCLK);
        check_eq("pre_reset_penable", 64'(PENABLE), 64'd1);
        PRESET = 1'b1;
        @(negedge PCLK);
        check_eq("midreset_bus", 64'({PSEL, PENABLE, rsp_valid}), 64'd0);
        check_eq("midreset_ready", 64'(cmd_ready), 64'd1);
        PRESET = 1'b0;
        expq.delete();
        repeat (6) @(negedge PCLK);

        // transfers still work after the mid-transfer reset
        send(1'b0, 32'h0000_0060, 32'h0, 32'h0F0F_F0F0, 2, 1'b0);
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
